seq_detect_moore: RTL and testbench

//  Parametrised Moore serial-pattern detector, successor to the fixed 4-bit detectors.
//  - Pattern width is a parameter; the pattern value is loadable at runtime.
//  - Selectable overlapping / non-overlapping matching.
//  - Input-valid qualifier, plus a saturating match counter.
//  - Sits on a 1-bit serial stream; feeds a status/interrupt block.

---
 rtl/seq_det_pkg.sv | 20 ++
 rtl/seq_next_state.sv | 37 +++
 rtl/seq_detect_moore.sv | 64 ++++++
 tb/tb_seq_detect_moore.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the parametrised serial-pattern detector.
// The state width covers 0..PAT_W_MAX matched bits.
package seq_det_pkg;

  localparam int PAT_W_MAX = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

  localparam int STATE_W = clog2(PAT_W_MAX + 1);

  typedef logic [STATE_W-1:0] state_t;

endpackage

// File: rtl/seq_next_state.sv
// Combinational next-state for the detector: longest pattern prefix that is a
// suffix of (first s pattern bits, then x). Pattern bit PAT_W-1 is received first.
module seq_next_state
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4
) (
  input  logic [PAT_W-1:0] pattern,
  input  state_t           s,
  input  logic             x,
  input  logic             overlap,
  output state_t           nxt
);

  int   s_eff;
  logic hit;

  always_comb begin
    // Without overlap, leaving DETECT restarts from an empty history.
    s_eff = (!overlap && int'(s) == PAT_W) ? 0 : int'(s);
    hit   = 1'b0;
    nxt   = '0;
    for (int k = 1; k <= PAT_W; k++) begin
      hit = 1'b0;
      if (k <= s_eff + 1) begin
        hit = (pattern[PAT_W-k] == x);
        for (int j = 0; j < PAT_W - 1; j++) begin
          if (j < k - 1 && pattern[PAT_W-1-j] != pattern[PAT_W-1-(s_eff+1-k+j)]) begin
            hit = 1'b0;
          end
        end
        if (hit) nxt = state_t'(k);
      end
    end
  end

endmodule

// File: rtl/seq_detect_moore.sv
// Moore serial-pattern detector with runtime-loadable pattern, overlap select,
// input-valid qualifier and a saturating match counter.
module seq_detect_moore
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             z,
  output logic [PAT_W-1:0] pattern,
  output logic [CNT_W-1:0] match_count
);

  localparam state_t           DETECT  = state_t'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  state_t nxt;
  logic   hit;

  seq_next_state #(.PAT_W(PAT_W)) u_next (
    .pattern (pattern),
    .s       (state),
    .x       (x),
    .overlap (overlap),
    .nxt     (nxt)
  );

  assign hit = in_valid && !pat_load && (nxt == DETECT);

  // z is registered alongside state so it always equals (state == DETECT).
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= '0;
      z       <= 1'b0;
      pattern <= PATTERN;
    end else if (pat_load) begin
      state   <= '0;
      z       <= 1'b0;
      pattern <= pat_in;
    end else if (in_valid) begin
      state   <= nxt;
      z       <= (nxt == DETECT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      match_count <= '0;
    end else if (hit && match_count != CNT_MAX) begin
      match_count <= match_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detect_moore.sv
// Scoreboard bench: a history-based reference model predicts z/pattern/count
// for two detector instances (8-bit and 2-bit counters) driven identically.
module tb_seq_detect_moore;

  logic       clk = 1'b0;
  logic       rst, x, in_valid, overlap, pat_load, cnt_clr;
  logic [3:0] pat_in;
  logic       z, z2;
  logic [3:0] pattern, pattern2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  seq_detect_moore #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .z(z), .pattern(pattern), .match_count(cnt8)
  );

  seq_detect_moore #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .z(z2), .pattern(pattern2), .match_count(cnt2)
  );

  typedef struct {
    logic       z;
    logic [3:0] pat;
    int         c8;
    int         c2;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   errors = 0;

  // Reference model: raw history of accepted bits (h[0] newest), valid length hl.
  logic [7:0] m_h;
  int         m_hl;
  int         m_s;
  logic [3:0] m_pat;
  int         m_c8, m_c2;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int match_len(input logic [7:0] h, input int hl, input logic [3:0] p);
    int best;
    best = 0;
    for (int k = 1; k <= 4; k++) begin
      if (k <= hl) begin
        bit ok;
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          if (p[3-j] != h[k-1-j]) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  task automatic model(input logic r, input logic xi, input logic v, input logic o,
                       input logic l, input logic [3:0] pi, input logic c);
    bit inc;
    inc = 1'b0;
    if (r) begin
      m_s = 0; m_hl = 0; m_h = '0; m_pat = 4'b1011; m_c8 = 0; m_c2 = 0;
    end else begin
      if (l) begin
        m_pat = pi; m_s = 0; m_hl = 0;
      end else if (v) begin
        if (!o && m_s == 4) m_hl = 0;
        m_h = {m_h[6:0], xi};
        if (m_hl < 8) m_hl++;
        m_s = match_len(m_h, m_hl, m_pat);
        inc = (m_s == 4);
      end
      if (c) begin
        m_c8 = 0; m_c2 = 0;
      end else if (inc) begin
        if (m_c8 < 255) m_c8++;
        if (m_c2 < 3) m_c2++;
      end
    end
  endtask

  task automatic step(input logic r, input logic xi, input logic v, input logic o,
                      input logic l, input logic [3:0] pi, input logic c);
    exp_t e;
    @(negedge clk);
    rst = r; x = xi; in_valid = v; overlap = o; pat_load = l; pat_in = pi; cnt_clr = c;
    model(r, xi, v, o, l, pi, c);
    e.z = (m_s == 4); e.pat = m_pat; e.c8 = m_c8; e.c2 = m_c2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("z", int'(z), int'(e.z));
    chk("z_w2", int'(z2), int'(e.z));
    chk("pattern", int'(pattern), int'(e.pat));
    chk("pattern_w2", int'(pattern2), int'(e.pat));
    chk("count8", int'(cnt8), e.c8);
    chk("count2", int'(cnt2), e.c2);
  endtask

  task automatic bit_in(input logic xi, input logic o);
    step(1'b0, xi, 1'b1, o, 1'b0, 4'b0, 1'b0);
  endtask

  task automatic stall(input logic o);
    step(1'b0, 1'b0, 1'b0, o, 1'b0, 4'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0, 1'b0);
  endtask

  logic [6:0] stream;

  initial begin
    rst = 1'b1; x = 1'b0; in_valid = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; pat_in = 4'b0; cnt_clr = 1'b0;
    m_s = 0; m_hl = 0; m_h = '0; m_pat = 4'b1011; m_c8 = 0; m_c2 = 0;
    stream = 7'b1011011;

    // Reset state
    do_reset();
    do_reset();
    chk("reset_z", int'(z), 0);
    chk("reset_pattern", int'(pattern), 4'b1011);
    chk("reset_count", int'(cnt8), 0);

    // 1: overlapping 1011011
    for (int i = 6; i >= 0; i--) begin
      bit_in(stream[i], 1'b1);
      if (i == 3 || i == 0) chk("t1_z_hit", int'(z), 1);
    end
    chk("t1_count", int'(cnt8), 2);

    // 2: same stream, non-overlapping
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      bit_in(stream[i], 1'b0);
      if (i == 3) chk("t2_z_hit", int'(z), 1);
      if (i == 0) chk("t2_z_nohit", int'(z), 0);
    end
    chk("t2_count", int'(cnt8), 1);

    // 3: load 1111, eight ones
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0);
    chk("t3_load_z", int'(z), 0);
    chk("t3_pattern", int'(pattern), 4'b1111);
    for (int i = 1; i <= 8; i++) begin
      bit_in(1'b1, 1'b1);
      chk("t3_z", int'(z), (i >= 4) ? 1 : 0);
    end
    chk("t3_count", int'(cnt8), 5);

    // 4: stall mid-sequence and while in DETECT
    do_reset();
    bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
    repeat (3) stall(1'b1);
    bit_in(1'b1, 1'b1);
    chk("t4_z_hit", int'(z), 1);
    repeat (2) begin
      stall(1'b1);
      chk("t4_z_hold", int'(z), 1);
    end

    // 5: reset mid-sequence
    do_reset();
    bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
    do_reset();
    bit_in(1'b1, 1'b1);
    chk("t5_z_after_rst", int'(z), 0);
    chk("t5_pattern", int'(pattern), 4'b1011);
    bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1);
    chk("t5_z_full", int'(z), 1);

    // 6: five overlapping matches saturate the 2-bit counter; clear beats a match
    do_reset();
    bit_in(1'b1, 1'b1);
    repeat (5) begin
      bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1);
    end
    chk("t6_sat", int'(cnt2), 3);
    chk("t6_cnt8", int'(cnt8), 5);
    bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0, 1'b1);
    chk("t6_clr_z", int'(z), 1);
    chk("t6_clr_cnt", int'(cnt2), 0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
           1'($urandom), ($urandom_range(0, 31) == 0), 4'($urandom),
           ($urandom_range(0, 47) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
